// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer slice.
// Holds the opcode and FSM state enums, the instruction field positions,
// the flag bit indices and a small opcode classification helper.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    XOR   = 4'd4,
    INC   = 4'd5,
    PASSA = 4'd6,
    PASSB = 4'd7,
    LOADI = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_e;

  localparam int unsigned REG_AW  = 3;

  // Instruction fields: [15:12] opcode, [11:9] dst, [8:6] src_a, [5:3] src_b
  localparam int unsigned OPC_HI  = 15;
  localparam int unsigned OPC_LO  = 12;
  localparam int unsigned DST_HI  = 11;
  localparam int unsigned DST_LO  = 9;
  localparam int unsigned SRCA_HI = 8;
  localparam int unsigned SRCA_LO = 6;
  localparam int unsigned SRCB_HI = 5;
  localparam int unsigned SRCB_LO = 3;

  // Flag vector is {overflow, negative, zero}
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  // Opcodes 0..7 go through the ALU
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file for the sequencer.
// Ports: clk, rst (sync clear), we/waddr/wdata (synchronous write),
// raddr_a/rdata_a and raddr_b/rdata_b (combinational reads),
// dbg_addr/dbg_data (combinational debug read).
// Reads always return the pre-write value during a write cycle.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned BW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [BW-1:0]     wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [BW-1:0]     rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [BW-1:0]     rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [BW-1:0]     dbg_data
);

  logic [BW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue instruction sequencer driving an external 16-bit ALU.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_instr/in_imm
// instruction handshake; alu_a/alu_b/alu_opcode to the ALU and
// alu_out/alu_flags back; done pulse, result and flags of the last
// retirement; dbg_addr/dbg_data combinational register peek.
// Sequence per instruction: IDLE (accept) -> EXEC (ALU inputs valid,
// writeback at closing edge) -> WB (done pulse) -> IDLE.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [BW-1:0]     in_imm,
  output logic [BW-1:0]     alu_a,
  output logic [BW-1:0]     alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [BW-1:0]     alu_out,
  input  logic [2:0]        alu_flags,
  output logic              done,
  output logic [BW-1:0]     result,
  output logic [2:0]        flags,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [BW-1:0]     dbg_data
);

  state_e            state;
  logic [3:0]        op_q;
  logic [REG_AW-1:0] dst_q;
  logic [BW-1:0]     imm_q;
  logic [BW-1:0]     rd_a;
  logic [BW-1:0]     rd_b;
  logic              we;
  logic [BW-1:0]     wdata;
  logic              unused_bits;

  assign unused_bits = ^in_instr[2:0];

  // Read ports are addressed straight from the incoming instruction: the
  // operands are registered onto alu_a/alu_b at the accept edge, which is
  // equivalent to reading in EXEC because nothing writes in between.
  alu_regfile #(
    .BW   (BW),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (dst_q),
    .wdata    (wdata),
    .raddr_a  (in_instr[SRCA_HI:SRCA_LO]),
    .rdata_a  (rd_a),
    .raddr_b  (in_instr[SRCB_HI:SRCB_LO]),
    .rdata_b  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    we    = 1'b0;
    wdata = imm_q;
    if (state == EXEC) begin
      if (is_alu_op(op_q)) begin
        we    = 1'b1;
        wdata = alu_out;
      end else if (op_q == LOADI) begin
        we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      done       <= 1'b0;
      result     <= '0;
      flags      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      op_q       <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid && in_ready) begin
            op_q       <= in_instr[OPC_HI:OPC_LO];
            dst_q      <= in_instr[DST_HI:DST_LO];
            imm_q      <= in_imm;
            alu_a      <= rd_a;
            alu_b      <= rd_b;
            alu_opcode <= in_instr[OPC_HI:OPC_LO];
            in_ready   <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (is_alu_op(op_q)) begin
            result <= alu_out;
            flags  <= alu_flags;
          end else if (op_q == LOADI) begin
            result <= imm_q;
          end
          alu_a      <= '0;
          alu_b      <= '0;
          alu_opcode <= '0;
          done       <= 1'b1;
          state      <= WB;
        end
        WB: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. Provides a behavioural stand-in
// for the external ALU, keeps a register-file model, pushes the expected
// retirement of every accepted instruction to a queue and pops it on done.
`timescale 1ns/1ps
module tb_alu_sequencer;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic        done;
  logic [15:0] result;
  logic [2:0]  flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int unsigned n_cmp    = 0;
  int unsigned n_bad    = 0;
  int unsigned n_done   = 0;
  int unsigned n_issued = 0;

  exp_t        q[$];
  logic [15:0] mreg [8];
  logic [15:0] mres;
  logic [2:0]  mflg;

  always #5 clk = ~clk;

  alu_sequencer #(
    .BW   (16),
    .NREG (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_imm     (in_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .done       (done),
    .result     (result),
    .flags      (flags),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Reference ALU: returns {ovf, neg, zero, out}
  function automatic logic [18:0] alu_f(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] s;
    logic        v;
    v = 1'b0;
    case (op)
      4'd0: begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
      4'd1: begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
      4'd2: s = a & b;
      4'd3: s = a | b;
      4'd4: s = a ^ b;
      4'd5: begin s = a + 16'd1; v = (a == 16'h7FFF); end
      4'd6: s = a;
      4'd7: s = b;
      default: s = 16'h0000;
    endcase
    return {v, s[15], (s == 16'h0000), s};
  endfunction

  assign {alu_flags, alu_out} = alu_f(alu_opcode, alu_a, alu_b);

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    mres = 16'h0000;
    mflg = 3'b000;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [2:0] dst,
                            input logic [2:0] sa, input logic [2:0] sb,
                            input logic [15:0] imm);
    logic [18:0] r;
    exp_t e;
    if (op < 4'd8) begin
      r = alu_f(op, mreg[sa], mreg[sb]);
      mreg[dst] = r[15:0];
      mres = r[15:0];
      mflg = r[18:16];
    end else if (op == 4'd8) begin
      mreg[dst] = imm;
      mres = imm;
    end
    e.res = mres;
    e.flg = mflg;
    q.push_back(e);
    n_issued++;
  endtask

  // Retirement monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      check_eq("done_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_eq("result", 32'(result), 32'(e.res));
        check_eq("flags", 32'(flags), 32'(e.flg));
      end
    end
  end

  // One instruction with cycle-by-cycle timing checks
  task automatic issue(input logic [3:0] op, input logic [2:0] dst,
                       input logic [2:0] sa, input logic [2:0] sb,
                       input logic [15:0] imm);
    logic [15:0] pa, pb, pd;
    bit ok;
    @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("accept_ready", 32'(ok), 32'd1);
    if (!ok) return;
    in_valid = 1'b1;
    in_instr = {op, dst, sa, sb, 3'($urandom)};
    in_imm   = imm;
    dbg_addr = dst;
    pa = mreg[sa];
    pb = mreg[sb];
    pd = mreg[dst];
    @(posedge clk);
    model_exec(op, dst, sa, sb, imm);
    #1;
    in_valid = 1'b0;
    in_instr = 16'($urandom);
    in_imm   = 16'($urandom);
    // E+1: EXEC
    check_eq("exec_ready", 32'(in_ready), 32'd0);
    check_eq("exec_done", 32'(done), 32'd0);
    check_eq("exec_alu_a", 32'(alu_a), 32'(pa));
    check_eq("exec_alu_b", 32'(alu_b), 32'(pb));
    check_eq("exec_alu_op", 32'(alu_opcode), 32'(op));
    check_eq("exec_dbg_old", 32'(dbg_data), 32'(pd));
    @(posedge clk); #1;
    // E+2: WB
    check_eq("wb_done", 32'(done), 32'd1);
    check_eq("wb_ready", 32'(in_ready), 32'd0);
    check_eq("wb_alu_a", 32'(alu_a), 32'd0);
    check_eq("wb_dbg_new", 32'(dbg_data), 32'(mreg[dst]));
    @(posedge clk); #1;
    // E+3: back in IDLE
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_all_regs(input string tag);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      check_eq(tag, 32'(dbg_data), 32'(mreg[r]));
    end
  endtask

  logic [15:0] b2b_instr [6];
  logic [15:0] b2b_imm   [6];

  initial begin
    int idx;
    bit acc;
    int unsigned done0;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    in_imm   = 16'h0000;
    dbg_addr = 3'd0;
    model_reset();

    // Reset has priority over a handshake presented during it
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_instr = {4'd8, 3'd7, 3'd0, 3'd0, 3'd0};
    in_imm   = 16'hFFFF;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("rst_alu_op", 32'(alu_opcode), 32'd0);
    check_all_regs("rst_reg");

    // Directed sequence
    issue(4'd8, 3'd1, 3'd0, 3'd0, 16'h0005);   // LOADI r1
    issue(4'd8, 3'd2, 3'd0, 3'd0, 16'h0003);   // LOADI r2
    issue(4'd0, 3'd3, 3'd1, 3'd2, 16'hDEAD);   // ADD r3 = r1 + r2
    check_eq("add_result", 32'(result), 32'h0008);
    dbg_addr = 3'd3; #1;
    check_eq("add_r3", 32'(dbg_data), 32'h0008);
    issue(4'hC, 3'd3, 3'd1, 3'd2, 16'h1234);   // NOP
    check_eq("nop_result", 32'(result), 32'h0008);
    check_eq("nop_flags", 32'(flags), 32'h0);
    issue(4'd1, 3'd4, 3'd2, 3'd1, 16'h0000);   // SUB r4 = r2 - r1
    dbg_addr = 3'd4; #1;
    check_eq("sub_r4", 32'(dbg_data), 32'hFFFE);
    check_eq("sub_flags", 32'(flags), 32'b010);
    issue(4'hF, 3'd4, 3'd0, 3'd0, 16'h0000);   // NOP keeps flags
    check_eq("nop2_flags", 32'(flags), 32'b010);
    issue(4'd8, 3'd6, 3'd0, 3'd0, 16'h0000);   // LOADI leaves flags
    check_eq("loadi_flags", 32'(flags), 32'b010);
    issue(4'd5, 3'd1, 3'd1, 3'd0, 16'h0000);   // INC r1 = r1 + 1
    dbg_addr = 3'd1; #1;
    check_eq("inc_r1", 32'(dbg_data), 32'h0006);
    issue(4'd8, 3'd7, 3'd0, 3'd0, 16'h7FFF);   // LOADI r7 = 0x7FFF
    issue(4'd0, 3'd7, 3'd7, 3'd7, 16'h0000);   // ADD overflow
    check_eq("ovf_flags", 32'(flags), 32'b110);
    issue(4'd1, 3'd0, 3'd7, 3'd7, 16'h0000);   // SUB -> zero
    check_eq("zero_flags", 32'(flags), 32'b001);
    check_all_regs("seq_reg");

    // Back-to-back with in_valid held high
    b2b_instr[0] = {4'd8, 3'd5, 3'd0, 3'd0, 3'd0}; b2b_imm[0] = 16'h00F0;
    b2b_instr[1] = {4'd3, 3'd2, 3'd5, 3'd1, 3'd5}; b2b_imm[1] = 16'h1111;
    b2b_instr[2] = {4'd4, 3'd3, 3'd2, 3'd5, 3'd2}; b2b_imm[2] = 16'h2222;
    b2b_instr[3] = {4'd9, 3'd3, 3'd0, 3'd0, 3'd0}; b2b_imm[3] = 16'h3333;
    b2b_instr[4] = {4'd2, 3'd6, 3'd3, 3'd2, 3'd7}; b2b_imm[4] = 16'h4444;
    b2b_instr[5] = {4'd7, 3'd0, 3'd1, 3'd4, 3'd1}; b2b_imm[5] = 16'h5555;
    done0 = n_done;
    idx = 0;
    for (int c = 0; idx < 6 && c < 60; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = b2b_instr[idx];
      in_imm   = b2b_imm[idx];
      check_eq("b2b_ready_pat", 32'(in_ready), 32'((c % 3) == 0));
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        model_exec(b2b_instr[idx][15:12], b2b_instr[idx][11:9],
                   b2b_instr[idx][8:6], b2b_instr[idx][5:3], b2b_imm[idx]);
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("b2b_all_accepted", 32'(idx), 32'd6);
    check_eq("b2b_queue_empty", 32'(q.size()), 32'd0);
    check_eq("b2b_done_count", 32'(n_done - done0), 32'd6);
    check_all_regs("b2b_reg");

    // Reset while ADD r5 is in EXEC
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {4'd0, 3'd5, 3'd1, 3'd2, 3'd0};
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("pre_rst_exec", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_result", 32'(result), 32'd0);
    check_eq("midrst_flags", 32'(flags), 32'd0);
    check_eq("midrst_alu_a", 32'(alu_a), 32'd0);
    check_all_regs("midrst_reg");
    repeat (3) @(negedge clk);

    // Recovery after reset
    issue(4'd8, 3'd5, 3'd0, 3'd0, 16'hA5A5);
    dbg_addr = 3'd5; #1;
    check_eq("recover_r5", 32'(dbg_data), 32'hA5A5);

    repeat (3) @(negedge clk);
    check_eq("final_done_count", 32'(n_done), 32'(n_issued));
    check_eq("final_queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
